// File: rtl/fetch_buffer_pkg.sv
// Shared fetch types: XLEN, the NOP word and the {pc, inst} entry.
// The ID stage reuses fetch_entry_t to unpack what the buffer hands it.
package fetch_buffer_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side bus: PC/imem in, stall out, decode head out.
// master = pipeline/memory side, slave = fetch_buffer.
interface fetch_buffer_if;
  import fetch_buffer_pkg::*;

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] imem_rdata;
  logic            flush;
  logic            id_stall;
  logic            fetch_stall;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] inst_d;
  logic            valid_d;

  modport master (
    output pc_f,
    output imem_rdata,
    output flush,
    output id_stall,
    input  fetch_stall,
    input  pc_d,
    input  inst_d,
    input  valid_d
  );

  modport slave (
    input  pc_f,
    input  imem_rdata,
    input  flush,
    input  id_stall,
    output fetch_stall,
    output pc_d,
    output inst_d,
    output valid_d
  );

endinterface

// File: rtl/fetch_buffer_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch entries.
// Ports: clk, rst, push/wdata, pop/rdata, clear, count, empty.
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // DEPTH need not be a power of two
  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (clear) begin
      // keep wr_ptr, realign reader onto it
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && push)
      mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: pairs imem words with their PC and queues them for ID.
// Ports: clk, rst (sync, active-high), bus (fetch_buffer_if.slave).
module fetch_buffer #(
  parameter int DEPTH = 3,
  parameter logic [fetch_buffer_pkg::XLEN-1:0] NOP_INST =
    fetch_buffer_pkg::NOP_INST
) (
  input  logic           clk,
  input  logic           rst,
  fetch_buffer_if.slave  bus
);
  import fetch_buffer_pkg::XLEN;
  import fetch_buffer_pkg::fetch_entry_t;

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic            req_valid;
  logic [XLEN-1:0] req_pc;
  logic [CW-1:0]   count;
  logic            empty;
  logic            stall;
  logic            push;
  logic            pop;
  fetch_entry_t    wdata;
  fetch_entry_t    head;

  // Registers only: no path from id_stall/flush.
  // Reserving a slot for the in-flight read keeps
  // push from ever meeting a full FIFO.
  assign stall = ({1'b0, count} + (CW + 1)'(req_valid))
                 >= DEPTH_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid <= 1'b0;
      req_pc    <= '0;
    end else begin
      req_pc    <= bus.pc_f;
      req_valid <= !stall && !bus.flush;
    end
  end

  assign push = req_valid && !bus.flush;
  assign pop  = !empty && !bus.id_stall && !bus.flush;

  assign wdata.pc   = req_pc;
  assign wdata.inst = bus.imem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (bus.flush),
    .wdata (wdata),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  always_comb begin
    bus.valid_d = !empty;
    bus.pc_d    = '0;
    bus.inst_d  = NOP_INST;
    if (!empty) begin
      bus.pc_d   = head.pc;
      bus.inst_d = head.inst;
    end
  end

  assign bus.fetch_stall = stall;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: cycle table + in-order scoreboard,
// plus a DEPTH=2 instance driven by a closed-loop PC.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst2;

  fetch_buffer_if bus ();
  fetch_buffer_if bus2 ();

  fetch_buffer #(.DEPTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_buffer #(.DEPTH(2)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] inst_of(
    input logic [31:0] pc
  );
    return {~pc[15:0], pc[15:0]};
  endfunction

  task automatic check(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // synchronous-read imem models
  always @(posedge clk)
    bus.imem_rdata <= inst_of(bus.pc_f);
  always @(posedge clk)
    bus2.imem_rdata <= inst_of(bus2.pc_f);

  // scoreboards: issue pushes pc, pop compares
  logic [31:0] sbq [$];
  logic [31:0] sbq2 [$];

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst || bus.flush) begin
      sbq.delete();
    end else begin
      if (bus.valid_d && !bus.id_stall) begin
        if (sbq.size() == 0) begin
          check("sb_underrun", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("sb_pc", bus.pc_d, e);
          check("sb_inst", bus.inst_d, inst_of(e));
        end
      end
      if (!bus.fetch_stall)
        sbq.push_back(bus.pc_f);
      checks++;
      assert (int'(dut.count) + int'(dut.req_valid) <= 3
              && !(dut.push && dut.count == 2'd3)
              && !(dut.pop && dut.count == 2'd0))
      else begin
        errors++;
        $display("FAIL inv3: count=%0d req_valid=%0d",
                 dut.count, dut.req_valid);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst2 || bus2.flush) begin
      sbq2.delete();
    end else begin
      if (bus2.valid_d && !bus2.id_stall) begin
        if (sbq2.size() == 0) begin
          check("sb2_underrun", 32'd1, 32'd0);
        end else begin
          e = sbq2.pop_front();
          check("sb2_pc", bus2.pc_d, e);
          check("sb2_inst", bus2.inst_d, inst_of(e));
        end
      end
      if (!bus2.fetch_stall)
        sbq2.push_back(bus2.pc_f);
      checks++;
      assert (int'(dut2.count) + int'(dut2.req_valid) <= 2
              && !(dut2.push && dut2.count == 2'd2)
              && !(dut2.pop && dut2.count == 2'd0))
      else begin
        errors++;
        $display("FAIL inv2: count=%0d req_valid=%0d",
                 dut2.count, dut2.req_valid);
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        flush;
    logic        id_stall;
    logic [31:0] pc_f;
    logic        chk;
    logic        v;
    logic [31:0] pc;
    logic        stall;
  } vec_t;

  vec_t tbl [$];

  task automatic add(
    input logic r, input logic f, input logic s,
    input logic [31:0] pf, input logic c,
    input logic v, input logic [31:0] pd,
    input logic st
  );
    vec_t t;
    t.rst = r; t.flush = f; t.id_stall = s;
    t.pc_f = pf; t.chk = c; t.v = v;
    t.pc = pd; t.stall = st;
    tbl.push_back(t);
  endtask

  initial begin
    logic [31:0] exp_inst;
    int pops, hi, lo;
    logic s;

    rst = 1'b1;
    bus.flush = 1'b0;
    bus.id_stall = 1'b0;
    bus.pc_f = '0;
    rst2 = 1'b1;
    bus2.flush = 1'b0;
    bus2.id_stall = 1'b0;
    bus2.pc_f = '0;

    // rst flush ids pc_f  chk v pc_d stall
    add(1,0,0,32'h000, 0,0,32'h000,0);
    add(1,0,0,32'h000, 1,0,32'h000,0);
    add(0,0,0,32'h000, 1,0,32'h000,0);
    add(0,0,0,32'h004, 1,0,32'h000,0);
    add(0,0,0,32'h008, 1,1,32'h000,0);
    add(0,0,0,32'h00c, 1,1,32'h004,0);
    add(0,0,0,32'h010, 1,1,32'h008,0);
    add(0,0,0,32'h014, 1,1,32'h00c,0);
    // decode stalls 5 cycles
    add(0,0,1,32'h018, 1,1,32'h010,0);
    add(0,0,1,32'h01c, 1,1,32'h010,1);
    add(0,0,1,32'h01c, 1,1,32'h010,1);
    add(0,0,1,32'h01c, 1,1,32'h010,1);
    add(0,0,1,32'h01c, 1,1,32'h010,1);
    add(0,0,0,32'h01c, 1,1,32'h010,1);
    add(0,0,0,32'h01c, 1,1,32'h014,0);
    add(0,0,0,32'h020, 1,1,32'h018,0);
    add(0,0,0,32'h024, 1,1,32'h01c,0);
    // build count=2, req_valid=1, then flush
    add(0,0,1,32'h028, 1,1,32'h020,0);
    add(0,1,0,32'h02c, 1,1,32'h020,1);
    add(0,0,0,32'h100, 1,0,32'h000,0);
    add(0,0,0,32'h104, 1,0,32'h000,0);
    add(0,0,0,32'h108, 1,1,32'h100,0);
    // flush while popping, then flush when empty
    add(0,1,0,32'h10c, 1,1,32'h104,0);
    add(0,1,0,32'h200, 1,0,32'h000,0);
    add(0,0,0,32'h200, 1,0,32'h000,0);
    add(0,0,0,32'h204, 1,0,32'h000,0);
    add(0,0,0,32'h208, 1,1,32'h200,0);
    add(0,0,0,32'h20c, 1,1,32'h204,0);
    // reset together with flush mid-stream
    add(1,1,0,32'h210, 1,1,32'h208,0);
    add(0,0,0,32'h000, 1,0,32'h000,0);
    add(0,0,0,32'h004, 1,0,32'h000,0);
    add(0,0,0,32'h008, 1,1,32'h000,0);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst = tbl[i].rst;
      bus.flush = tbl[i].flush;
      bus.id_stall = tbl[i].id_stall;
      bus.pc_f = tbl[i].pc_f;
      @(negedge clk);
      if (tbl[i].chk) begin
        exp_inst = tbl[i].v ? inst_of(tbl[i].pc)
                            : 32'h0000_0013;
        check($sformatf("row%0d_valid", i),
              32'(bus.valid_d), 32'(tbl[i].v));
        check($sformatf("row%0d_pc", i),
              bus.pc_d, tbl[i].pc);
        check($sformatf("row%0d_inst", i),
              bus.inst_d, exp_inst);
        check($sformatf("row%0d_stall", i),
              32'(bus.fetch_stall), 32'(tbl[i].stall));
      end
    end

    // DEPTH=2: PC advances only when not stalled
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    pops = 0;
    hi = 0;
    lo = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      s = bus2.fetch_stall;
      if (bus2.valid_d) pops++;
      if (s) hi++;
      else lo++;
      @(posedge clk);
      #1;
      if (!s) bus2.pc_f = bus2.pc_f + 32'd4;
    end
    check("d2_stall_high_seen", 32'(hi > 0), 32'd1);
    check("d2_stall_low_seen", 32'(lo > 0), 32'd1);
    check("d2_throughput", 32'(pops >= 14), 32'd1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
